// File: rtl/mem_stage_access_unit.sv
// MEM-stage sequencer: converts an EX/MEM load/store into a dcache req/ready
// handshake, stalls the pipeline until completion and keeps access/wait counters.
module mem_stage_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] write_data_in,
  output logic        dcache_req,
  output logic        dcache_we,
  output logic [15:0] dcache_addr,
  output logic [15:0] dcache_wdata,
  input  logic        dcache_ready,
  input  logic [15:0] dcache_rdata,
  output logic        stall_mem,
  output logic [15:0] load_data_out,
  output logic        load_valid_out,
  output logic [15:0] access_count,
  output logic [15:0] wait_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic        req_reg;
  logic        we_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] load_data_reg;
  logic        load_valid_reg;
  logic [15:0] count_reg;
  logic [15:0] wait_reg;
  logic        access;

  assign access = valid_in & (mem_read_in | mem_write_in);

  // DONE never stalls, so EX/MEM advances on the edge leaving DONE and the
  // next instruction is first examined in IDLE.
  assign stall_mem = ((state_reg == IDLE) & access) | (state_reg == REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= 16'h0000;
      wdata_reg      <= 16'h0000;
      load_data_reg  <= 16'h0000;
      load_valid_reg <= 1'b0;
      count_reg      <= 16'h0000;
      wait_reg       <= 16'h0000;
    end else begin
      load_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (access) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
            // Read+write together resolves to a store.
            we_reg    <= mem_write_in;
            addr_reg  <= addr_in;
            wdata_reg <= write_data_in;
          end
        end
        REQ: begin
          // The request runs to completion even if valid_in drops meanwhile.
          if (dcache_ready) begin
            state_reg <= DONE;
            req_reg   <= 1'b0;
            count_reg <= count_reg + 16'd1;
            if (!we_reg) begin
              load_data_reg  <= dcache_rdata;
              load_valid_reg <= 1'b1;
            end
          end else if (wait_reg != 16'hFFFF) begin
            wait_reg <= wait_reg + 16'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign dcache_req     = req_reg;
  assign dcache_we      = we_reg;
  assign dcache_addr    = addr_reg;
  assign dcache_wdata   = wdata_reg;
  assign load_data_out  = load_data_reg;
  assign load_valid_out = load_valid_reg;
  assign access_count   = count_reg;
  assign wait_cycles    = wait_reg;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed cases, random
// transactions and counter saturation, against a transaction-level model.
module tb_mem_stage_access_unit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [15:0] addr_in;
  logic [15:0] write_data_in;
  logic        dcache_req;
  logic        dcache_we;
  logic [15:0] dcache_addr;
  logic [15:0] dcache_wdata;
  logic        dcache_ready;
  logic [15:0] dcache_rdata;
  logic        stall_mem;
  logic [15:0] load_data_out;
  logic        load_valid_out;
  logic [15:0] access_count;
  logic [15:0] wait_cycles;

  int          total;
  int          bad;
  logic [15:0] exp_count;
  logic [15:0] exp_load;
  int          exp_wait;

  mem_stage_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .addr_in       (addr_in),
    .write_data_in (write_data_in),
    .dcache_req    (dcache_req),
    .dcache_we     (dcache_we),
    .dcache_addr   (dcache_addr),
    .dcache_wdata  (dcache_wdata),
    .dcache_ready  (dcache_ready),
    .dcache_rdata  (dcache_rdata),
    .stall_mem     (stall_mem),
    .load_data_out (load_data_out),
    .load_valid_out(load_valid_out),
    .access_count  (access_count),
    .wait_cycles   (wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE just after an edge; returns in IDLE just after an edge.
  task automatic do_access(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] wd, input int nwait,
                           input logic [15:0] rdat, input bit drop);
    bit is_load;
    is_load       = rd && !wr;
    valid_in      = 1'b1;
    mem_read_in   = rd;
    mem_write_in  = wr;
    addr_in       = a;
    write_data_in = wd;
    dcache_ready  = 1'($urandom);
    dcache_rdata  = 16'($urandom);
    #1;
    check("idle_stall", 16'(stall_mem), 16'd1);
    check("idle_req", 16'(dcache_req), 16'd0);
    check("idle_lvalid", 16'(load_valid_out), 16'd0);
    tick();
    if (drop) valid_in = 1'b0;
    for (int i = 0; i <= nwait; i++) begin
      dcache_ready = (i == nwait);
      dcache_rdata = (i == nwait) ? rdat : 16'($urandom);
      #1;
      if (nwait < 8 || i == 0 || i == nwait) begin
        check("req_req", 16'(dcache_req), 16'd1);
        check("req_we", 16'(dcache_we), 16'(wr));
        check("req_addr", dcache_addr, a);
        check("req_wdata", dcache_wdata, wd);
        check("req_stall", 16'(stall_mem), 16'd1);
      end
      tick();
    end
    exp_count = exp_count + 16'd1;
    exp_wait  = exp_wait + nwait;
    if (exp_wait > 65535) exp_wait = 65535;
    if (is_load) exp_load = rdat;
    dcache_ready = 1'($urandom);
    dcache_rdata = 16'($urandom);
    #1;
    check("done_stall", 16'(stall_mem), 16'd0);
    check("done_req", 16'(dcache_req), 16'd0);
    check("done_lvalid", 16'(load_valid_out), 16'(is_load));
    check("done_ldata", load_data_out, exp_load);
    check("done_count", access_count, exp_count);
    check("done_wait", wait_cycles, 16'(exp_wait));
    tick();
  endtask

  // Bubble or non-memory instruction in IDLE: no request, no stall.
  task automatic idle_cycle();
    valid_in     = 1'($urandom);
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    addr_in      = 16'($urandom);
    dcache_ready = 1'($urandom);
    #1;
    check("nop_stall", 16'(stall_mem), 16'd0);
    check("nop_req", 16'(dcache_req), 16'd0);
    check("nop_lvalid", 16'(load_valid_out), 16'd0);
    check("nop_ldata", load_data_out, exp_load);
    tick();
  endtask

  initial begin
    bit rd, wr;
    total = 0;
    bad = 0;
    exp_count = 16'h0000;
    exp_load = 16'h0000;
    exp_wait = 0;

    // Reset held with a live load pending.
    reset = 1'b1;
    valid_in = 1'b1;
    mem_read_in = 1'b1;
    mem_write_in = 1'b0;
    addr_in = 16'h0040;
    write_data_in = 16'h5555;
    dcache_ready = 1'b1;
    dcache_rdata = 16'hAAAA;
    tick();
    tick();
    check("rst_req", 16'(dcache_req), 16'd0);
    check("rst_we", 16'(dcache_we), 16'd0);
    check("rst_addr", dcache_addr, 16'h0000);
    check("rst_wdata", dcache_wdata, 16'h0000);
    check("rst_ldata", load_data_out, 16'h0000);
    check("rst_lvalid", 16'(load_valid_out), 16'd0);
    check("rst_count", access_count, 16'h0000);
    check("rst_wait", wait_cycles, 16'h0000);
    check("rst_stall", 16'(stall_mem), 16'd1);
    reset = 1'b0;

    // Zero-wait load, then 3-wait store, then read+write store.
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 1'b0);
    do_access(1'b0, 1'b1, 16'h0100, 16'h1234, 3, 16'h0000, 1'b0);
    do_access(1'b1, 1'b1, 16'h0200, 16'h4321, 1, 16'h7777, 1'b0);
    // Bubble arrives while the request is outstanding.
    do_access(1'b1, 1'b0, 16'h0300, 16'h0000, 2, 16'hCAFE, 1'b1);
    idle_cycle();
    idle_cycle();

    // Reset while in REQ with ready high: no pulse, counters cleared.
    valid_in = 1'b1;
    mem_read_in = 1'b1;
    mem_write_in = 1'b0;
    addr_in = 16'h0400;
    dcache_ready = 1'b0;
    tick();
    check("rreq_req", 16'(dcache_req), 16'd1);
    reset = 1'b1;
    valid_in = 1'b0;
    dcache_ready = 1'b1;
    dcache_rdata = 16'hDEAD;
    tick();
    check("rreq_req_off", 16'(dcache_req), 16'd0);
    check("rreq_lvalid", 16'(load_valid_out), 16'd0);
    check("rreq_count", access_count, 16'h0000);
    check("rreq_ldata", load_data_out, 16'h0000);
    check("rreq_stall", 16'(stall_mem), 16'd0);
    reset = 1'b0;
    exp_count = 16'h0000;
    exp_load = 16'h0000;
    exp_wait = 0;
    idle_cycle();

    // Random traffic with random bubbles between accesses.
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      do_access(rd, wr, 16'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
                16'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Long wait drives wait_cycles into saturation.
    do_access(1'b0, 1'b1, 16'hFFFE, 16'h0F0F, 65540, 16'h0000, 1'b0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
